// File: rtl/lomuto_partitioner_pkg.sv
// Shared sort types: store geometry, element/index types, partition FSM states, float ordering key.
// Latency: none (types, constants and a pure function only).
// Backpressure: none.
package sort_pkg;

  localparam int K  = 10;
  localparam int N  = 23;
  localparam int M  = 8;
  localparam int L  = N + M + 1;
  localparam int S  = $clog2(K) + 1;
  localparam int AW = $clog2(K);

  typedef logic [L-1:0] elem_t;
  typedef logic [S-1:0] idx_t;
  typedef logic [S:0]   wide_idx_t;

  localparam idx_t      K_IDX  = idx_t'(K);
  localparam wide_idx_t K_WIDE = wide_idx_t'(K);

  typedef enum logic [2:0] {
    IDLE,
    PIVOT,
    SCAN,
    FINAL,
    DONE
  } state_t;

  // Map a sign/magnitude float onto an unsigned key with the same ordering:
  // negatives get all bits inverted so larger magnitudes sort lower, positives
  // get the sign bit set so they sort above every negative (-0 lands below +0).
  function automatic elem_t float_key(input elem_t e);
    if (e[L-1]) begin
      float_key = ~e;
    end else begin
      float_key = {1'b1, e[L-2:0]};
    end
  endfunction

endpackage

// File: rtl/lomuto_partitioner_float_lt.sv
// Strict less-than between two floats via the unsigned ordering key.
// Latency: combinational.
// Backpressure: none.
module float_lt
  import sort_pkg::*;
(
  input  elem_t a,
  input  elem_t b,
  output logic  lt
);

  assign lt = (float_key(a) < float_key(b));

endmodule

// File: rtl/lomuto_partitioner.sv
// Lomuto partition of store[lo..lo+cnt-1] around its last element; index = final pivot slot.
// Latency: done pulses cnt+2 cycles after start (1 cycle for cnt<=1 or out-of-range).
// Backpressure: start and wr_en are ignored while busy. Optional LOMUTO_SWAP_COUNT_EN adds swap_count.
module lomuto_partitioner
  import sort_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  wr_en,
  input  idx_t  wr_addr,
  input  elem_t wr_data,
  input  idx_t  rd_addr,
  output elem_t rd_data,
  input  logic  start,
  input  idx_t  start_index,
  input  idx_t  element_count,
  output logic  busy,
  output logic  done,
  output idx_t  index,
  output logic  range_err
`ifdef LOMUTO_SWAP_COUNT_EN
  ,
  output idx_t  swap_count
`endif
);

  state_t    state;
  idx_t      hi;
  idx_t      i;
  idx_t      j;
  elem_t     pivot;
  elem_t     mem [K];

  elem_t     mem_i;
  elem_t     mem_j;
  elem_t     mem_hi;
  wide_idx_t hi_calc;
  idx_t      hi_m1;
  logic      start_ok;
  logic      trivial;
  logic      out_of_range;
  logic      scan_lt;
  logic      scan_swap;
  logic      final_swap;
  logic      load_ok;

  // Out-of-range addresses read as zero; in-flight ranges are always < K.
  assign rd_data = (rd_addr < K_IDX) ? mem[rd_addr[AW-1:0]] : '0;
  assign mem_i   = (i  < K_IDX) ? mem[i[AW-1:0]]  : '0;
  assign mem_j   = (j  < K_IDX) ? mem[j[AW-1:0]]  : '0;
  assign mem_hi  = (hi < K_IDX) ? mem[hi[AW-1:0]] : '0;

  // hi needs one extra bit so lo+cnt-1 past the top of the index range is still caught.
  assign hi_calc      = wide_idx_t'(start_index) + wide_idx_t'(element_count) - wide_idx_t'(1);
  assign hi_m1        = hi - idx_t'(1);
  assign start_ok     = (state == IDLE) && start;
  assign trivial      = (element_count <= idx_t'(1));
  assign out_of_range = (hi_calc >= K_WIDE);
  assign load_ok      = (state == IDLE) && wr_en && (wr_addr < K_IDX);

  float_lt u_scan_lt (
    .a  (mem_j),
    .b  (pivot),
    .lt (scan_lt)
  );

  assign scan_swap  = (state == SCAN) && scan_lt;
  assign final_swap = (state == FINAL);

  // Element store: external loads when idle, otherwise the scan / final swaps.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < K; k++) begin
        mem[k] <= '0;
      end
    end else if (load_ok) begin
      mem[wr_addr[AW-1:0]] <= wr_data;
    end else if (scan_swap) begin
      // i == j writes the same value twice, so no special case is needed.
      mem[i[AW-1:0]] <= mem_j;
      mem[j[AW-1:0]] <= mem_i;
    end else if (final_swap) begin
      mem[i[AW-1:0]]  <= mem_hi;
      mem[hi[AW-1:0]] <= mem_i;
    end
  end

  // Partition sequencer with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      index     <= '0;
      range_err <= 1'b0;
      hi        <= '0;
      i         <= '0;
      j         <= '0;
      pivot     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            i         <= start_index;
            j         <= start_index;
            hi        <= hi_calc[S-1:0];
            range_err <= 1'b0;
            if (trivial) begin
              index <= start_index;
              done  <= 1'b1;
              state <= DONE;
            end else if (out_of_range) begin
              index     <= start_index;
              range_err <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= PIVOT;
            end
          end
        end
        PIVOT: begin
          pivot <= mem_hi;
          state <= SCAN;
        end
        SCAN: begin
          if (scan_lt) begin
            i <= i + idx_t'(1);
          end
          j <= j + idx_t'(1);
          if (j == hi_m1) begin
            state <= FINAL;
          end
        end
        FINAL: begin
          index <= i;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef LOMUTO_SWAP_COUNT_EN
  // Count only swaps that actually move data between two distinct slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      swap_count <= '0;
    end else if (start_ok) begin
      swap_count <= '0;
    end else if ((scan_swap && (i != j)) || (final_swap && (i != hi))) begin
      swap_count <= swap_count + idx_t'(1);
    end
  end
`endif

endmodule

// File: tb/tb_lomuto_partitioner.sv
// Directed bench for lomuto_partitioner: hand-computed vectors plus a small key-ordering model.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
// Ends with one TB_RESULT summary line.
module tb_lomuto_partitioner;
  import sort_pkg::*;

  localparam elem_t F_P0  = 32'h0000_0000;
  localparam elem_t F_N0  = 32'h8000_0000;
  localparam elem_t F_N1  = 32'hBF80_0000;
  localparam elem_t F_1   = 32'h3F80_0000;
  localparam elem_t F_1P5 = 32'h3FC0_0000;
  localparam elem_t F_2   = 32'h4000_0000;
  localparam elem_t F_3   = 32'h4040_0000;
  localparam elem_t F_4   = 32'h4080_0000;
  localparam elem_t F_5   = 32'h40A0_0000;

  logic  clk = 1'b0;
  logic  reset;
  logic  wr_en;
  idx_t  wr_addr;
  elem_t wr_data;
  idx_t  rd_addr;
  elem_t rd_data;
  logic  start;
  idx_t  start_index;
  idx_t  element_count;
  logic  busy;
  logic  done;
  idx_t  index;
  logic  range_err;
`ifdef LOMUTO_SWAP_COUNT_EN
  idx_t  swap_count;
`endif

  int    n_checks = 0;
  int    n_fail   = 0;
  elem_t model [K];

  always #5 clk = ~clk;

  lomuto_partitioner dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .start         (start),
    .start_index   (start_index),
    .element_count (element_count),
    .busy          (busy),
    .done          (done),
    .index         (index),
    .range_err     (range_err)
`ifdef LOMUTO_SWAP_COUNT_EN
    ,
    .swap_count    (swap_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Independent ordering key: sign bit flipped, magnitude bits inverted for negatives.
  function automatic elem_t tb_key(input elem_t e);
    tb_key = {~e[L-1], e[L-1] ? ~e[L-2:0] : e[L-2:0]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < K; k++) model[k] = '0;
  endtask

  task automatic write_mem(input int addr, input elem_t data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = idx_t'(addr);
    wr_data = data;
    @(posedge clk);
    #1 wr_en = 1'b0;
    model[addr] = data;
  endtask

  task automatic read_mem(input int addr, output elem_t data);
    rd_addr = idx_t'(addr);
    #1 data = rd_data;
  endtask

  task automatic check_mem_model(input string tag);
    elem_t v;
    for (int k = 0; k < K; k++) begin
      read_mem(k, v);
      check($sformatf("%s_mem%0d", tag, k), v, model[k]);
    end
  endtask

  // Reference Lomuto partition on the bench's copy of the store.
  task automatic model_part(input int lo, input int cnt, output int idx, output int swaps);
    int    hi;
    int    ii;
    elem_t pv;
    elem_t t;
    hi    = lo + cnt - 1;
    idx   = lo;
    swaps = 0;
    if (cnt > 1 && hi < K) begin
      pv = model[hi];
      ii = lo;
      for (int jj = lo; jj < hi; jj++) begin
        if (tb_key(model[jj]) < tb_key(pv)) begin
          t = model[ii]; model[ii] = model[jj]; model[jj] = t;
          if (ii != jj) swaps++;
          ii++;
        end
      end
      t = model[ii]; model[ii] = model[hi]; model[hi] = t;
      if (ii != hi) swaps++;
      idx = ii;
    end
  endtask

  // Issue one start and count cycles to done; optionally try a write while busy.
  task automatic run_part(input int lo, input int cnt, input logic poke,
                          output int cyc, output logic busy_c1, output logic busy_at_done);
    @(negedge clk);
    start         = 1'b1;
    start_index   = idx_t'(lo);
    element_count = idx_t'(cnt);
    cyc           = 0;
    busy_c1       = 1'b0;
    busy_at_done  = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      if (poke && cyc == 2) begin
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 32'h1234_5678;
      end else begin
        wr_en = 1'b0;
      end
      if (cyc == 1) busy_c1 = busy;
      if (done) begin
        busy_at_done = busy;
        break;
      end
    end
    wr_en = 1'b0;
    check("done_seen", done, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    cyc;
    int    m_idx;
    int    m_sw;
    logic  b1;
    logic  bd;
    elem_t v;

    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    start = 1'b0; start_index = '0; element_count = '0;
    do_reset();

    // Reset state
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_index", index, '0);
    check("rst_range_err", range_err, 1'b0);
    read_mem(0, v); check("rst_mem0", v, '0);
    read_mem(9, v); check("rst_mem9", v, '0);
`ifdef LOMUTO_SWAP_COUNT_EN
    check("rst_swap_count", swap_count, '0);
`endif

    // Test 1: {3,1,4,1.5,2} around pivot 2.0
    write_mem(0, F_3); write_mem(1, F_1); write_mem(2, F_4);
    write_mem(3, F_1P5); write_mem(4, F_2);
    run_part(0, 5, 1'b0, cyc, b1, bd);
    model_part(0, 5, m_idx, m_sw);
    check("t1_cycles", cyc, 7);
    check("t1_busy_c1", b1, 1'b1);
    check("t1_busy_at_done", bd, 1'b0);
    check("t1_index", index, 2);
    check("t1_range_err", range_err, 1'b0);
    read_mem(0, v); check("t1_m0", v, F_1);
    read_mem(1, v); check("t1_m1", v, F_1P5);
    read_mem(2, v); check("t1_m2", v, F_2);
    read_mem(3, v); check("t1_m3", v, F_3);
    read_mem(4, v); check("t1_m4", v, F_4);
`ifdef LOMUTO_SWAP_COUNT_EN
    check("t1_swap_count", swap_count, 3);
`endif
    @(posedge clk); #1;
    check("t1_done_one_cycle", done, 1'b0);

    // Test 2: signed zeros; key order is -1.0 < -0.0 < +0.0, pivot is -0.0
    write_mem(3, F_N1); write_mem(4, F_P0); write_mem(5, F_N0);
    run_part(3, 3, 1'b0, cyc, b1, bd);
    model_part(3, 3, m_idx, m_sw);
    check("t2_cycles", cyc, 5);
    check("t2_index_model", index, m_idx);
    check("t2_index", index, 4);
    read_mem(3, v); check("t2_m3", v, F_N1);
    read_mem(4, v); check("t2_m4", v, F_N0);
    read_mem(5, v); check("t2_m5", v, F_P0);
    check_mem_model("t2");
`ifdef LOMUTO_SWAP_COUNT_EN
    check("t2_swap_count", swap_count, m_sw);
`endif

    // Test 3: all-equal store, pivot ends at lo
    for (int k = 0; k < K; k++) write_mem(k, F_5);
    run_part(0, 10, 1'b0, cyc, b1, bd);
    model_part(0, 10, m_idx, m_sw);
    check("t3_cycles", cyc, 12);
    check("t3_index", index, 0);
    check_mem_model("t3");
`ifdef LOMUTO_SWAP_COUNT_EN
    check("t3_swap_count", swap_count, 1);
`endif

    // Distinct descending values so any stray swap is visible
    for (int k = 0; k < K; k++) write_mem(k, elem_t'(32'h4100_0000 - k * 32'h0010_0000));

    // Test 4: single element
    run_part(4, 1, 1'b0, cyc, b1, bd);
    check("t4_cycles", cyc, 1);
    check("t4_busy_c1", b1, 1'b0);
    check("t4_index", index, 4);
    check("t4_range_err", range_err, 1'b0);
    check_mem_model("t4");
`ifdef LOMUTO_SWAP_COUNT_EN
    check("t4_swap_count", swap_count, 0);
`endif

    // Test 5: range past the end of the store
    run_part(8, 5, 1'b0, cyc, b1, bd);
    check("t5_cycles", cyc, 1);
    check("t5_range_err", range_err, 1'b1);
    check("t5_index", index, 8);
    check_mem_model("t5");

    // Test 6: second start while busy is ignored, then reset mid-operation
    @(negedge clk);
    start = 1'b1; start_index = idx_t'(0); element_count = idx_t'(10);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 start = 1'b1; start_index = idx_t'(5); element_count = idx_t'(2);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    check("t6_busy_c5", busy, 1'b1);
    check("t6_done_c5", done, 1'b0);
    check("t6_index_held", index, 8);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < K; k++) model[k] = '0;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_done", done, 1'b0);
    check("t6_rst_index", index, '0);
`ifdef LOMUTO_SWAP_COUNT_EN
    check("t6_rst_swap_count", swap_count, '0);
`endif
    check_mem_model("t6_rst");

    // Test 7: write attempted while busy must not land
    write_mem(0, F_1); write_mem(1, F_3); write_mem(2, F_2);
    run_part(0, 3, 1'b1, cyc, b1, bd);
    model_part(0, 3, m_idx, m_sw);
    check("t7_cycles", cyc, 5);
    check("t7_index", index, 1);
    read_mem(0, v); check("t7_m0_no_write", v, F_1);
    read_mem(1, v); check("t7_m1", v, F_2);
    read_mem(2, v); check("t7_m2", v, F_3);
`ifdef LOMUTO_SWAP_COUNT_EN
    check("t7_swap_count", swap_count, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
